// File: rtl/sprite_update_master_pkg.sv
// Shared definitions for the sprite update master.
//   ADDR_W_DEF / DATA_W_DEF : default Avalon address / write-data widths
//   state_e                 : master FSM states
//   cmd_t                   : one queued register update {last, addr, data}
package sprite_update_master_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 16;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_e;

    typedef struct packed {
        logic                  last;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } cmd_t;

    localparam int CMD_W_DEF = $bits(cmd_t);

endpackage

// File: rtl/sprite_update_master_cmd_fifo.sv
// cmd_fifo: command FIFO holding packed {last, addr, data} register updates.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   push_i, wdata_i : write an entry (ignored while full)
//   pop_i           : drop the head entry (ignored while empty)
//   rdata_o         : current head entry (first-word fall-through)
//   full_o, empty_o : occupancy flags
//   count_o         : number of stored entries
module cmd_fifo
    import sprite_update_master_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = CMD_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [W-1:0]           wdata_i,
    input  logic                   pop_i,
    output logic [W-1:0]           rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage carries no reset; only valid entries are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/sprite_update_master.sv
// sprite_update_master: queues sprite/boundary register updates in batches and
// replays each complete batch as back-to-back Avalon-MM writes during vblank.
// Ports:
//   clk, reset                          : clock, asynchronous active-high reset
//   in_valid/in_ready/in_addr/in_data/in_last : update input stream
//   vblank                              : display outside active region
//   avm_chipselect/avm_write/avm_address/avm_writedata/avm_waitrequest : Avalon master
//   batches_pending                     : complete batches queued, not yet started
//   batch_done                          : one-cycle pulse after a batch's last write
module sprite_update_master
    import sprite_update_master_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_W-1:0]      in_addr,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_last,
    input  logic                   vblank,
    output logic                   avm_chipselect,
    output logic                   avm_write,
    output logic [ADDR_W-1:0]      avm_address,
    output logic [DATA_W-1:0]      avm_writedata,
    input  logic                   avm_waitrequest,
    output logic [$clog2(DEPTH):0] batches_pending,
    output logic                   batch_done
);
    localparam int CMD_W = 1 + ADDR_W + DATA_W;
    localparam int PW    = $clog2(DEPTH) + 1;

    logic [CMD_W-1:0]  push_cmd, head_cmd;
    logic              fifo_full, fifo_empty;
    logic [PW-1:0]     fifo_count;
    logic              push, pop, start;
    logic              head_last;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    state_e        state_q, state_d;
    logic [PW-1:0] pend_q, pend_d;
    logic          done_q, done_d;

    assign push_cmd  = {in_last, in_addr, in_data};
    assign head_last = head_cmd[CMD_W-1];
    assign head_addr = head_cmd[DATA_W +: ADDR_W];
    assign head_data = head_cmd[DATA_W-1:0];

    assign in_ready = ~fifo_full;
    assign push     = in_valid & ~fifo_full;
    // The head entry is consumed exactly when the slave accepts the write.
    assign pop      = (state_q == S_WRITE) & ~avm_waitrequest;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_cmd_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i (push_cmd),
        .pop_i   (pop),
        .rdata_o (head_cmd),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A pending batch is always fully resident, so the FIFO
                // cannot run dry before its last entry is written.
                if (vblank && (pend_q != '0) && !fifo_empty && (fifo_count != '0)) begin
                    state_d = S_WRITE;
                    start   = 1'b1;
                end
            end
            S_WRITE: begin
                // vblank is ignored here: a started batch always completes.
                if (!avm_waitrequest && head_last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pend_d = pend_q;
        case ({push & in_last, start})
            2'b10:   pend_d = pend_q + PW'(1);
            2'b01:   pend_d = pend_q - PW'(1);
            default: pend_d = pend_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
        end
    end

    // The FIFO head stays put while stalled, so the bus fields hold stable
    // through waitrequest and step to the next entry right after acceptance.
    assign avm_write       = (state_q == S_WRITE);
    assign avm_chipselect  = avm_write;
    assign avm_address     = avm_write ? head_addr : '0;
    assign avm_writedata   = avm_write ? head_data : '0;
    assign batches_pending = pend_q;
    assign batch_done      = done_q;

endmodule

// File: doc/sprite_update_master.md
SPRITE_UPDATE_MASTER -- requirements
Module: sprite_update_master

Interface
REQ-001 Parameter DEPTH, default 8, command FIFO depth in entries (power of two, 2..32).
REQ-002 Parameter ADDR_W, default 6, Avalon register address width.
REQ-003 Parameter DATA_W, default 16, Avalon write data width.
REQ-004 clk  input  1  system clock, 50 MHz domain shared with the display peripheral.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  producer offers a register update.
REQ-007 in_ready  output  1  block can accept an update this cycle.
REQ-008 in_addr  input  ADDR_W  target register address (boundary, sprite x/y/img).
REQ-009 in_data  input  DATA_W  value for that register.
REQ-010 in_last  input  1  this update closes a batch (one frame's worth of updates).
REQ-011 vblank  input  1  level, high while display is outside the active region.
REQ-012 avm_chipselect  output  1  Avalon-MM master chipselect.
REQ-013 avm_write  output  1  Avalon-MM master write strobe.
REQ-014 avm_address  output  ADDR_W  Avalon-MM master address.
REQ-015 avm_writedata  output  DATA_W  Avalon-MM master write data.
REQ-016 avm_waitrequest  input  1  slave stall; write is held while high.
REQ-017 batches_pending  output  $clog2(DEPTH)+1  complete batches in the FIFO, not yet started.
REQ-018 batch_done  output  1  one-cycle pulse when the last write of a batch is accepted.

Function
REQ-019 Push occurs on a cycle with in_valid && in_ready; {in_last, in_addr, in_data} is stored in FIFO order.
REQ-020 in_ready = FIFO not full; it is registered-state derived and does not depend on in_valid; a full FIFO does not drop data.
REQ-021 batches_pending increments on a push with in_last=1; it decrements when the FSM leaves IDLE to start a batch; if both occur in one cycle, it stays unchanged.
REQ-022 FSM states: IDLE, WRITE.
REQ-023 IDLE -> WRITE when vblank=1 and batches_pending>0. On that edge, the FIFO head is presented on avm_address and avm_writedata, and avm_chipselect=avm_write=1 from the next cycle.
REQ-024 In WRITE, avm_chipselect, avm_write, avm_address and avm_writedata hold stable while avm_waitrequest=1.
REQ-025 A write is accepted on a cycle in WRITE with avm_waitrequest=0. The head entry pops that cycle.
REQ-026 On acceptance with the entry's last=0, the FSM stays in WRITE and presents the next FIFO entry the following cycle, giving back-to-back writes with no idle gap.
REQ-027 On acceptance with last=1, the FSM returns to IDLE, deasserts avm_chipselect and avm_write the next cycle, and pulses batch_done for one cycle.
REQ-028 Batches are atomic: once started, a batch completes even if vblank falls mid-batch. A new batch starts only from IDLE with vblank=1.
REQ-029 Back-to-back batches are allowed. If vblank=1 and batches_pending>0 in IDLE, the next batch starts the cycle after the previous one ends.
REQ-030 Entries pushed after the last in_last (an incomplete batch) are never issued until their in_last is pushed.
REQ-031 Simultaneous push and pop when the FIFO is full is legal only for the pop side; in_ready=0 blocks the push that cycle.
REQ-032 FIFO pointers wrap modulo DEPTH. Occupancy uses a separate counter of width $clog2(DEPTH)+1.
REQ-033 avm_chipselect equals avm_write at all times; the block never issues reads.

Reset
REQ-034 On reset assertion, asynchronously: FSM=IDLE, FIFO empty, pointers=0, batches_pending=0, avm_chipselect=0, avm_write=0, avm_address=0, avm_writedata=0, batch_done=0, in_ready=1 after the first clock edge following reset release.
REQ-035 Reset mid-batch abandons the batch; no further avm_write is issued, and all queued entries are discarded.

Structure
REQ-036 A shared package holds the ADDR_W/DATA_W defaults, the FSM state enum, and a packed command struct {last, addr, data}.
REQ-037 The FIFO is one sub-module, cmd_fifo (push/pop, full/empty, count), instantiated once.

Verification
REQ-038 Batch of 3 ((0x4,0x0A0),(0x5,0x121),(0x6,0x001,last)) pushed with vblank=0 -> no avm_write; raise vblank -> 3 consecutive accepted writes in order, then batch_done pulse, batches_pending 1->0.
REQ-039 Same batch, avm_waitrequest=1 for 4 cycles on the 2nd write -> address 0x5 and data 0x121 held stable for 5 cycles, no duplication or skip.
REQ-040 Push 8 entries without in_last -> in_ready=0 after the 8th, no writes even with vblank=1; set in_last on the 8th -> 8 writes issue.
REQ-041 vblank falls after the 1st of 3 writes -> the remaining 2 writes still issue; a second queued batch waits for the next vblank.
REQ-042 Push of a last entry in the same cycle as a batch start -> batches_pending unchanged (1->1).
REQ-043 Assert reset during the 2nd write -> avm_write=0 immediately, batches_pending=0, no writes after release.
